dram_wbuf: RTL and testbench

- Data-memory store buffer sitting directly downstream of the hxd32 core's DRAM port, between the core and a single-port synchronous data SRAM.
- Absorbs core stores into a small FIFO and drains them to the SRAM in cycles when no load is using the port.
- Forwards buffered bytes to loads so program order is preserved.
- Raises a stall when it cannot accept a core request.

---
 rtl/hxd32_pkg.sv | 11 +
 rtl/wbuf_fwd.sv | 33 +++
 rtl/dram_wbuf.sv | 112 +++++++++++
 tb/tb_dram_wbuf.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/hxd32_pkg.sv
// hxd32_pkg: shared store-buffer entry type and word-address constants for the hxd32 data path
package hxd32_pkg;
  localparam int WB_XLEN   = 32;
  localparam int WB_ADDR_W = 12;
  localparam int WORD_LSB  = 2;
  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_XLEN-1:0]   data;
    logic [3:0]           be;
  } wbuf_entry_t;
endpackage

// File: rtl/wbuf_fwd.sv
// wbuf_fwd: per-byte merge of buffered stores matching a word address, youngest entry wins each lane
module wbuf_fwd
  import hxd32_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  wbuf_entry_t          entries_i [DEPTH],
  input  logic [DEPTH-1:0]     valid_i,
  input  logic [PW-1:0]        head_i,
  input  logic [CW-1:0]        count_i,
  input  logic [WB_ADDR_W-1:0] addr_i,
  output logic [WB_XLEN-1:0]   data_o,
  output logic [3:0]           mask_o
);
  logic [PW-1:0] idx;
  // Walk oldest to youngest so later matches overwrite earlier ones.
  always_comb begin
    data_o = '0;
    mask_o = '0;
    idx    = head_i;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PW'(i);
      if (CW'(i) < count_i && valid_i[idx] && entries_i[idx].addr == addr_i)
        for (int b = 0; b < 4; b++)
          if (entries_i[idx].be[b]) begin
            data_o[8*b +: 8] = entries_i[idx].data[8*b +: 8];
            mask_o[b]        = 1'b1;
          end
    end
  end
endmodule

// File: rtl/dram_wbuf.sv
// dram_wbuf: store buffer between the core DRAM port and a single-port SRAM, with load forwarding
module dram_wbuf
  import hxd32_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              dram_rd_en_i,
  input  logic [XLEN-1:0]   dram_rd_addr_i,
  output logic [XLEN-1:0]   dram_rd_data_o,
  input  logic [XLEN-1:0]   dram_wr_addr_i,
  input  logic [XLEN-1:0]   dram_wr_data_i,
  input  logic [3:0]        dram_wr_byte_en_i,
  output logic              stall_o,
  output logic              empty_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_wr_en_o,
  output logic [3:0]        sram_byte_en_o,
  output logic [XLEN-1:0]   sram_wr_data_o,
  input  logic [XLEN-1:0]   sram_rd_data_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  wbuf_entry_t       ent_q [DEPTH];
  wbuf_entry_t       ent_d [DEPTH];
  wbuf_entry_t       head;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              empty_q, ld_pend_q;
  logic [XLEN-1:0]   fwd_data_q, fwd_data_d, rd_hold_q, rd_hold_d;
  logic [3:0]        fwd_mask_q, fwd_mask_d;
  logic [XLEN-1:0]   fwd_data, ld_data;
  logic [3:0]        fwd_mask;
  logic [ADDR_W-1:0] ld_addr, st_addr;
  logic              full, ld_acc, st_req, st_acc, drain;
  logic              unused_addr;
  assign unused_addr = ^{dram_rd_addr_i[XLEN-1:ADDR_W+WORD_LSB], dram_rd_addr_i[WORD_LSB-1:0],
                         dram_wr_addr_i[XLEN-1:ADDR_W+WORD_LSB], dram_wr_addr_i[WORD_LSB-1:0]};
  assign ld_addr = dram_rd_addr_i[ADDR_W+WORD_LSB-1:WORD_LSB];
  assign st_addr = dram_wr_addr_i[ADDR_W+WORD_LSB-1:WORD_LSB];
  assign head    = ent_q[rd_ptr_q];
  // Gating with rst_n_i keeps the SRAM strobe and core handshake quiet during reset.
  assign full    = count_q == CW'(DEPTH);
  assign ld_acc  = rst_n_i && dram_rd_en_i && !full;
  assign drain   = rst_n_i && count_q != '0 && (full || !ld_acc);
  assign st_req  = dram_wr_byte_en_i != 4'b0;
  assign st_acc  = rst_n_i && st_req && (!full || drain);
  assign stall_o = rst_n_i && ((dram_rd_en_i && !ld_acc) || (st_req && !st_acc));
  assign empty_o = empty_q;
  assign sram_wr_en_o   = drain;
  assign sram_addr_o    = drain ? head.addr : (ld_acc ? ld_addr : '0);
  assign sram_byte_en_o = drain ? head.be : 4'b0;
  assign sram_wr_data_o = drain ? head.data : '0;
  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign ld_data[8*b +: 8] = fwd_mask_q[b] ? fwd_data_q[8*b +: 8] : sram_rd_data_i[8*b +: 8];
  end
  assign dram_rd_data_o = ld_pend_q ? ld_data : rd_hold_q;
  wbuf_fwd #(.DEPTH(DEPTH)) u_fwd (
    .entries_i (ent_q),
    .valid_i   (valid_q),
    .head_i    (rd_ptr_q),
    .count_i   (count_q),
    .addr_i    (ld_addr),
    .data_o    (fwd_data),
    .mask_o    (fwd_mask)
  );
  // Pop is applied before push so a full-buffer push into the popped slot stays valid.
  always_comb begin
    ent_d   = ent_q;
    valid_d = valid_q;
    if (drain) valid_d[rd_ptr_q] = 1'b0;
    if (st_acc) begin
      ent_d[wr_ptr_q]   = '{addr: st_addr, data: dram_wr_data_i, be: dram_wr_byte_en_i};
      valid_d[wr_ptr_q] = 1'b1;
    end
    wr_ptr_d   = st_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = drain ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(st_acc) - CW'(drain);
    fwd_data_d = ld_acc ? fwd_data : fwd_data_q;
    fwd_mask_d = ld_acc ? fwd_mask : fwd_mask_q;
    rd_hold_d  = ld_pend_q ? ld_data : rd_hold_q;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      valid_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      ld_pend_q  <= 1'b0;
      fwd_data_q <= '0;
      fwd_mask_q <= '0;
      rd_hold_q  <= '0;
    end else begin
      ent_q      <= ent_d;
      valid_q    <= valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= count_d == '0;
      ld_pend_q  <= ld_acc;
      fwd_data_q <= fwd_data_d;
      fwd_mask_q <= fwd_mask_d;
      rd_hold_q  <= rd_hold_d;
    end
  end
endmodule

// File: tb/tb_dram_wbuf.sv
// tb_dram_wbuf: directed stimulus against a program-order memory model, compared every cycle
module tb_dram_wbuf;
  localparam int DEPTH = 4;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        rd_en;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic [3:0]  wr_be;
  logic [31:0] rd_data, sram_wdata;
  logic [31:0] sram_rdata = '0;
  logic        stall, empty, sram_we;
  logic [11:0] sram_addr;
  logic [3:0]  sram_be;
  typedef struct {logic [11:0] a; logic [31:0] d; logic [3:0] be;} st_t;
  st_t         st_q[$];
  logic [31:0] mem  [4096];
  logic [31:0] arch [4096];
  logic [31:0] exp_rd = '0;
  int          n_chk = 0, n_fail = 0;
  bit          chk_en = 1'b0;

  dram_wbuf #(.XLEN(32), .DEPTH(DEPTH), .ADDR_W(12)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .dram_rd_en_i(rd_en), .dram_rd_addr_i(rd_addr), .dram_rd_data_o(rd_data),
    .dram_wr_addr_i(wr_addr), .dram_wr_data_i(wr_data), .dram_wr_byte_en_i(wr_be),
    .stall_o(stall), .empty_o(empty),
    .sram_addr_o(sram_addr), .sram_wr_en_o(sram_we), .sram_byte_en_o(sram_be),
    .sram_wr_data_o(sram_wdata), .sram_rd_data_i(sram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port SRAM: read-before-write, one cycle read latency.
  always @(posedge clk) begin
    sram_rdata <= mem[sram_addr];
    if (sram_we)
      for (int b = 0; b < 4; b++) if (sram_be[b]) mem[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void decide(output bit la, output bit dr, output bit sa);
    int n;
    bit full;
    n    = st_q.size();
    full = (n == DEPTH);
    la   = rd_en && !full;
    dr   = n > 0 && (full || !la);
    sa   = (wr_be != 4'b0) && (!full || dr);
  endfunction

  // Model: arch holds memory as the program sees it; st_q is what has not reached the SRAM yet.
  always @(posedge clk) if (rst_n) begin : mdl
    bit la, dr, sa;
    decide(la, dr, sa);
    if (la) exp_rd = arch[rd_addr[13:2]];
    if (dr) st_q.delete(0);
    if (sa) begin
      st_q.push_back('{wr_addr[13:2], wr_data, wr_be});
      for (int b = 0; b < 4; b++) if (wr_be[b]) arch[wr_addr[13:2]][8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  always @(negedge clk) if (chk_en && rst_n) begin : cmp
    bit la, dr, sa;
    st_t h;
    decide(la, dr, sa);
    if (st_q.size() > 0) h = st_q[0];
    else h = '{default: '0};
    check("stall", {31'b0, stall}, {31'b0, (rd_en && !la) || (wr_be != 4'b0 && !sa)});
    check("sram_we", {31'b0, sram_we}, {31'b0, dr});
    check("sram_addr", {20'b0, sram_addr}, {20'b0, dr ? h.a : (la ? rd_addr[13:2] : 12'h0)});
    check("sram_be", {28'b0, sram_be}, {28'b0, dr ? h.be : 4'h0});
    check("sram_wdata", sram_wdata, dr ? h.d : 32'h0);
    check("empty", {31'b0, empty}, {31'b0, st_q.size() == 0});
    check("rd_data", rd_data, exp_rd);
  end

  task automatic drive(input logic re, input logic [31:0] ra, input logic [31:0] wa,
                       input logic [31:0] wd, input logic [3:0] be);
    rd_en = re; rd_addr = ra; wr_addr = wa; wr_data = wd; wr_be = be;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin mem[i] = '0; arch[i] = '0; end
    mem[8] = 32'h11223344; arch[8] = 32'h11223344;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_we", {31'b0, sram_we}, 32'd0);
    check("rst_rd_data", rd_data, 32'h0);
    rst_n = 1'b1; chk_en = 1'b1;
    tick();
    check("idle_empty", {31'b0, empty}, 32'd1);
    check("idle_stall", {31'b0, stall}, 32'd0);
    // single store drains in the following idle cycle
    drive(0, 0, 32'h10, 32'hDEADBEEF, 4'hF); tick();
    drive(0, 0, 0, 0, 0); #1;
    check("drain_we", {31'b0, sram_we}, 32'd1);
    check("drain_addr", {20'b0, sram_addr}, 32'h4);
    check("drain_data", sram_wdata, 32'hDEADBEEF);
    check("drain_empty_before", {31'b0, empty}, 32'd0);
    tick();
    check("drain_empty_after", {31'b0, empty}, 32'd1);
    // single-lane forward over SRAM data
    drive(0, 0, 32'h20, 32'h000000AA, 4'h1); tick();
    drive(1, 32'h20, 0, 0, 0); tick();
    check("fwd_lane0", rd_data, 32'h112233AA);
    drive(0, 0, 0, 0, 0); tick();
    check("rd_hold", rd_data, 32'h112233AA);
    tick();
    // lane merge, then younger store overrides
    drive(0, 0, 32'h30, 32'h00000001, 4'h1); tick();
    drive(0, 0, 32'h30, 32'h00000200, 4'h2); tick();
    drive(1, 32'h30, 0, 0, 0); tick();
    check("merge", rd_data, 32'h00000201);
    drive(0, 0, 32'h30, 32'h000000FF, 4'h1); tick();
    drive(1, 32'h30, 0, 0, 0); tick();
    check("youngest", rd_data, 32'h000002FF);
    drive(0, 0, 0, 0, 0); repeat (3) tick();
    // fill with loads holding the port, then forced drain
    drive(1, 32'h40, 32'h40, 32'h00000011, 4'h1); tick();
    drive(1, 32'h40, 32'h40, 32'h00002222, 4'h3); tick();
    drive(1, 32'h40, 32'h40, 32'h00000033, 4'h1); tick();
    drive(1, 32'h40, 32'h40, 32'h44000000, 4'h8); tick();
    check("fill_load", rd_data, 32'h00002233);
    drive(1, 32'h40, 32'h40, 32'h00000055, 4'h1); #1;
    check("full_stall", {31'b0, stall}, 32'd1);
    check("full_drain_we", {31'b0, sram_we}, 32'd1);
    check("full_drain_addr", {20'b0, sram_addr}, 32'h10);
    tick();
    drive(1, 32'h40, 0, 0, 0); #1;
    check("full_stall2", {31'b0, stall}, 32'd1);
    tick();
    #1;
    check("stall_release", {31'b0, stall}, 32'd0);
    tick();
    check("full_fwd", rd_data, 32'h44002255);
    drive(0, 0, 0, 0, 0); repeat (5) tick();
    // reset while three stores are buffered and one is draining
    drive(1, 32'h60, 32'h60, 32'h000000A1, 4'hF); tick();
    drive(1, 32'h60, 32'h64, 32'h000000A2, 4'hF); tick();
    drive(1, 32'h60, 32'h68, 32'h000000A3, 4'hF); tick();
    drive(0, 0, 0, 0, 0); #1;
    check("pre_rst_we", {31'b0, sram_we}, 32'd1);
    #1 rst_n = 1'b0;
    st_q.delete();
    exp_rd = '0;
    for (int i = 0; i < 4096; i++) arch[i] = mem[i];
    #1;
    check("arst_we", {31'b0, sram_we}, 32'd0);
    check("arst_be", {28'b0, sram_be}, 32'd0);
    check("arst_addr", {20'b0, sram_addr}, 32'd0);
    check("arst_wdata", sram_wdata, 32'd0);
    check("arst_empty", {31'b0, empty}, 32'd1);
    check("arst_rd_data", rd_data, 32'd0);
    drive(1, 32'h60, 32'h70, 32'h1, 4'hF); #1;
    check("arst_stall", {31'b0, stall}, 32'd0);
    check("arst_addr_req", {20'b0, sram_addr}, 32'd0);
    drive(0, 0, 0, 0, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    drive(1, 32'h60, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0); #1;
    check("lost_store", rd_data, 32'h0);
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
